insn_decode: RTL
================

INSN_DECODE -- requirements
Module: insn_decode

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous reset, active low.
REQ-004 byte_in  input  8  opcode or operand byte from the instruction fetch stage.
REQ-005 byte_valid  input  1  byte_in is valid this cycle.
REQ-006 byte_ready  output  1  decoder accepts byte_in this cycle (accept = byte_valid & byte_ready).
REQ-007 flush  input  1  discard any partial or held instruction (jump or task switch).
REQ-008 pull_decoded  input  1  fetch stage consumes the held decoded instruction.
REQ-009 decoded_valid  output  1  decoded_insn and the flags are valid.
REQ-010 decoded_insn  output  24  {opcode, operand1, operand2}; missing operands are zero.
REQ-011 need_operand  output  1  next accepted byte is an operand, not an opcode.
REQ-012 insn_noop, insn_suspend, insn_pull, insn_jump  output  1 each  class flags for the held instruction.

Function
REQ-013 States SHALL be IDLE (await opcode), OP1 (await operand 1), OP2 (await operand 2) and HOLD (decoded_valid=1).
REQ-014 Operand count SHALL be: byte_in[7:4]==4'h1 -> 1 (jump); otherwise byte_in[7:6]: 00/01 -> 0, 10 -> 1, 11 -> 2.
REQ-015 Class SHALL be: 8'h00 -> noop; 8'h01 -> suspend; 8'h02 -> pull; 8'h1X -> jump; all other opcodes -> no flag set.
REQ-016 IDLE, opcode accepted: the opcode SHALL be latched into decoded_insn[23:16] and bits [15:0] cleared; the next state SHALL be HOLD for 0 operands, otherwise OP1.
REQ-017 OP1, byte accepted: the byte SHALL be latched into [15:8]; the next state SHALL be OP2 for a 2-operand opcode, otherwise HOLD.
REQ-018 OP2, byte accepted: the byte SHALL be latched into [7:0]; the next state SHALL be HOLD.
REQ-019 Latency: decoded_valid SHALL rise on the clock edge that accepts the last byte of the instruction, i.e. it is visible the cycle after that byte is presented.
REQ-020 A jump target is {opcode[3:0], operand1} (12 bits); the block SHALL carry it only in decoded_insn, with no separate port.
REQ-021 need_operand SHALL be 1 exactly in OP1 and OP2, derived from state only.
REQ-022 byte_ready SHALL be 1 in IDLE, OP1 and OP2, and in HOLD only when pull_decoded=1.
REQ-023 HOLD with pull_decoded=1 and no accepted byte: the next state SHALL be IDLE and decoded_valid SHALL fall.
REQ-024 HOLD with pull_decoded=1 and an accepted opcode in the same cycle: the block SHALL behave as IDLE accepting that opcode (back-to-back, no bubble).
REQ-025 HOLD with pull_decoded=0: decoded_insn, the flags and decoded_valid SHALL be held unchanged, and no byte SHALL be accepted.
REQ-026 pull_decoded outside HOLD SHALL be ignored.
REQ-027 The class flags SHALL be 0 whenever decoded_valid=0.
REQ-028 flush=1 SHALL take priority over every other input: next state IDLE, decoded_valid=0, flags 0, and byte_in that cycle discarded.
REQ-029 flush and pull_decoded together SHALL act as flush alone.
REQ-030 byte_valid=0 SHALL leave all state unchanged, apart from pull and flush effects.

Reset
REQ-031 While reset_n=0, the block SHALL force state IDLE and decoded_valid, decoded_insn, need_operand and all flags to 0, immediately and without waiting for clk.
REQ-032 After reset_n rises, the first clock edge SHALL be able to accept an opcode.
REQ-033 Reset asserted in any state, including HOLD or mid-operand, SHALL discard the partial or held instruction.

Verification
REQ-034 Reset, then byte 8'h5A with valid for one cycle -> next cycle: decoded_valid=1, decoded_insn=24'h5A0000, all flags 0, need_operand=0.
REQ-035 Bytes 8'h13 then 8'h45 on consecutive cycles -> need_operand=1 after the first; after the second: decoded_insn=24'h134500, insn_jump=1, target 12'h345.
REQ-036 Bytes 8'hC7, 8'h11, 8'h22 -> need_operand=1 for two cycles, then decoded_insn=24'hC71122 with no flags set.
REQ-037 In HOLD, present 8'h01 with pull_decoded=0 for 3 cycles -> byte_ready=0 and the output is held. Then assert pull_decoded with the byte in the same cycle -> next cycle: decoded_insn=24'h010000, insn_suspend=1.
REQ-038 Byte 8'h80 then flush=1 in OP1 -> state IDLE, need_operand=0, decoded_valid=0. Then byte 8'h02 -> insn_pull=1, decoded_insn=24'h020000.
REQ-039 Drive reset_n low mid-cycle while in HOLD -> decoded_valid and all flags 0 before the next clk edge.

Source files
------------

// File: rtl/insn_decode_if.sv
// Fetch-to-decoder bus: one byte per accepted beat in, one held decoded instruction out.
// The fetch side (master) drives bytes, flush and pull; the decoder (slave) drives ready and results.
interface insn_decode_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic        pull_decoded;
    logic        decoded_valid;
    logic [23:0] decoded_insn;
    logic        need_operand;
    logic        insn_noop;
    logic        insn_suspend;
    logic        insn_pull;
    logic        insn_jump;

    modport master (
        output byte_in, byte_valid, flush, pull_decoded,
        input  byte_ready, decoded_valid, decoded_insn, need_operand,
        input  insn_noop, insn_suspend, insn_pull, insn_jump
    );

    modport slave (
        input  byte_in, byte_valid, flush, pull_decoded,
        output byte_ready, decoded_valid, decoded_insn, need_operand,
        output insn_noop, insn_suspend, insn_pull, insn_jump
    );
endinterface

// File: rtl/insn_decode.sv
// Byte-serial instruction decoder: assembles opcode plus 0-2 operands into a held 24-bit word.
// Latency: valid on the edge accepting the last byte; backpressure: byte_ready low while holding unless pulled.
module insn_decode (
    input  logic         clk,
    input  logic         reset_n,
    insn_decode_if.slave dec_if
);
    typedef enum logic [1:0] {IDLE, OP1, OP2, HOLD} state_t;

    state_t      state_q, state_d;
    logic [23:0] insn_q, insn_d;
    logic        byte_rdy;
    logic        accept;

    function automatic logic [1:0] op_count(input logic [7:0] op);
        logic [1:0] n;
        if (op[7:4] == 4'h1) begin
            n = 2'd1;
        end else begin
            case (op[7:6])
                2'b10:   n = 2'd1;
                2'b11:   n = 2'd2;
                default: n = 2'd0;
            endcase
        end
        return n;
    endfunction

    // A pulled HOLD frees the slot in the same cycle so the next opcode lands without a bubble.
    assign byte_rdy = (state_q != HOLD) | dec_if.pull_decoded;
    assign accept   = dec_if.byte_valid & byte_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            insn_q  <= '0;
        end else begin
            state_q <= state_d;
            insn_q  <= insn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        insn_d  = insn_q;
        if (dec_if.flush) begin
            state_d = IDLE;
            insn_d  = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (accept) begin
                        insn_d  = {dec_if.byte_in, 16'h0000};
                        state_d = (op_count(dec_if.byte_in) == 2'd0) ? HOLD : OP1;
                    end else if (state_q == HOLD && dec_if.pull_decoded) begin
                        state_d = IDLE;
                    end
                end
                OP1: begin
                    if (accept) begin
                        insn_d[15:8] = dec_if.byte_in;
                        state_d      = (op_count(insn_q[23:16]) == 2'd2) ? OP2 : HOLD;
                    end
                end
                OP2: begin
                    if (accept) begin
                        insn_d[7:0] = dec_if.byte_in;
                        state_d     = HOLD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        dec_if.byte_ready    = byte_rdy;
        dec_if.decoded_valid = (state_q == HOLD);
        dec_if.need_operand  = (state_q == OP1) || (state_q == OP2);
        dec_if.decoded_insn  = insn_q;
        dec_if.insn_noop     = 1'b0;
        dec_if.insn_suspend  = 1'b0;
        dec_if.insn_pull     = 1'b0;
        dec_if.insn_jump     = 1'b0;
        if (state_q == HOLD) begin
            dec_if.insn_noop    = (insn_q[23:16] == 8'h00);
            dec_if.insn_suspend = (insn_q[23:16] == 8'h01);
            dec_if.insn_pull    = (insn_q[23:16] == 8'h02);
            dec_if.insn_jump    = (insn_q[23:20] == 4'h1);
        end
    end
endmodule
